// File: rtl/multiply_seq_if.sv
// Start/operand/result bundle between the MIPS core and the iterative multiplier.
// The core (master) issues MULT/MULTU requests; the multiplier (slave) returns HI:LO.
interface multiply_seq_if #(
    parameter int WIDTH = 32
);
    logic                   MUL_START;
    logic                   SIGNED;
    logic [WIDTH-1:0]       MULTIPLICAND;
    logic [WIDTH-1:0]       MULTIPLIER;
    logic [2*WIDTH-1:0]     PRODUCT;
    logic                   ready;
    logic                   mul_busy;

    modport master (
        output MUL_START, SIGNED, MULTIPLICAND, MULTIPLIER,
        input  PRODUCT, ready, mul_busy
    );

    modport slave (
        input  MUL_START, SIGNED, MULTIPLICAND, MULTIPLIER,
        output PRODUCT, ready, mul_busy
    );
endinterface

// File: rtl/multiply_seq.sv
// Iterative shift-add multiplier for MULT/MULTU: one partial product per clock,
// WIDTH steps per operation, sign applied to the magnitude product at the end.
module multiply_seq #(
    parameter int WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RST,
    multiply_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     mplier_reg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [CW-1:0]        count;
    logic                 neg;
    logic                 ready_q;
    logic                 busy_q;
    logic                 accept;
    logic                 last_step;

    // Magnitudes as W-bit unsigned values; the most negative operand maps to 2^(W-1).
    assign mag_a = (bus.SIGNED && bus.MULTIPLICAND[WIDTH-1]) ? -bus.MULTIPLICAND
                                                               : bus.MULTIPLICAND;
    assign mag_b = (bus.SIGNED && bus.MULTIPLIER[WIDTH-1])   ? -bus.MULTIPLIER
                                                               : bus.MULTIPLIER;

    // Accumulator value including this cycle's partial product; used for the final step too.
    assign acc_step  = acc + (mplier_reg[0] ? mcand_reg : '0);
    assign accept    = bus.MUL_START && (state_q != RUN);
    assign last_step = (state_q == RUN) && (count == CW'(WIDTH - 1));

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (bus.MUL_START) state_d = RUN;
            RUN:        if (last_step)     state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc        <= '0;
            count      <= '0;
            neg        <= 1'b0;
            product_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (accept) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_b;
            acc        <= '0;
            count      <= '0;
            neg        <= bus.SIGNED & (bus.MULTIPLICAND[WIDTH-1] ^ bus.MULTIPLIER[WIDTH-1]);
            product_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else if (state_q == RUN) begin
            acc        <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count      <= count + 1'b1;
            if (last_step) begin
                product_q <= neg ? -acc_step : acc_step;
                ready_q   <= 1'b1;
                busy_q    <= 1'b0;
            end
        end
    end

    assign bus.PRODUCT  = product_q;
    assign bus.ready    = ready_q;
    assign bus.mul_busy = busy_q;
endmodule
